// File: rtl/reduce_table.sv
// reduce_table: reduction-table consumer for the children-annotated packet stream.
// Each in-flight reduction sits in one table entry keyed by (index, algtype).
// Contributions are folded into the stored payload with the entry's op. Once
// every child has reported and the adder-latency wait has run out, the entry
// is released as a finished 64-bit packet.
// Optional build macro: REDUCE_TABLE_BYPASS_EN. When it is defined, packets
// with the reduction bit clear skip the table and go straight to the output
// register. When it is undefined, those packets are consumed and dropped.
module reduce_table #(
  parameter int ReductionTableSize = 2,
  parameter int AdderLatency       = 14,
  parameter int WaitWidth          = 4,
  parameter int ChildrenWidth      = 3,
  parameter int PayloadLen         = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ChildrenWidth+63:0]  packetIn,
  output logic                       inReady,
  output logic [63:0]                packetOut,
  output logic                       outValid,
  input  logic                       outReady
);

  localparam int N    = ReductionTableSize;
  localparam int IdxW = (N > 1) ? $clog2(N) : 1;

  // Per-entry control state.
  logic [N-1:0]             ent_valid;
  logic [N-1:0]             ent_count;   // counting down toward release
  logic [WaitWidth-1:0]     ent_wait [N];
  logic [ChildrenWidth-1:0] ent_rem  [N];
  // Stored packet bits [61:0]; the low PayloadLen bits hold the running result.
  logic [61:0]              ent_data [N];

  logic [N-1:0]  match;
  logic          hit, has_free, any_elig;
  logic [IdxW-1:0] hit_idx, free_idx, elig_idx;
  logic          load_ok, rel, take, do_hit, do_alloc, bypass_load;

  logic in_valid, is_red;
  assign in_valid = packetIn[63];
  assign is_red   = packetIn[62];

  function automatic logic [PayloadLen-1:0] combine(input logic [1:0] op,
                                                    input logic [PayloadLen-1:0] a,
                                                    input logic [PayloadLen-1:0] b);
    case (op)
      2'd0:    return a + b;            // wraps at PayloadLen bits
      2'd1:    return (a > b) ? a : b;
      2'd2:    return (a < b) ? a : b;
      default: return a | b;
    endcase
  endfunction

  // Entry lookup: matching entry, lowest free entry and lowest eligible entry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    match    = '0;
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    any_elig = 1'b0;
    elig_idx = '0;
    // Descending scan so the lowest-numbered candidate is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      match[i] = ent_valid[i] && (ent_data[i][44:37] == packetIn[44:37]) &&
                 (ent_data[i][45] == packetIn[45]) && (ent_rem[i] != '0);
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
      if (!ent_valid[i]) begin
        has_free = 1'b1;
        free_idx = IdxW'(i);
      end
      if (ent_valid[i] && ent_count[i] && (ent_wait[i] == '0)) begin
        any_elig = 1'b1;
        elig_idx = IdxW'(i);
      end
    end
  end

  assign load_ok = !outValid || outReady;
  assign rel     = load_ok && any_elig;

`ifdef REDUCE_TABLE_BYPASS_EN
  // A bypass packet may only take the output register when no entry wants it.
  assign inReady     = is_red ? (hit || has_free) : (load_ok && !any_elig);
  assign bypass_load = in_valid && !is_red && load_ok && !any_elig;
`else
  // Non-reduction packets are always accepted and then dropped.
  assign inReady     = is_red ? (hit || has_free) : 1'b1;
  assign bypass_load = 1'b0;
`endif

  assign take     = in_valid && is_red && inReady;
  assign do_hit   = take && hit;
  assign do_alloc = take && !hit;

  // Control state: wait countdown, release, combine bookkeeping and allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_count <= '0;
      for (int i = 0; i < N; i++) begin
        ent_wait[i] <= '0;
        ent_rem[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ent_count[i] && (ent_wait[i] != '0))
          ent_wait[i] <= ent_wait[i] - 1'b1;
      end
      if (rel) begin
        ent_valid[elig_idx] <= 1'b0;
        ent_count[elig_idx] <= 1'b0;
      end
      if (do_hit) begin
        ent_rem[hit_idx]  <= ent_rem[hit_idx] - 1'b1;
        ent_wait[hit_idx] <= WaitWidth'(AdderLatency);
        if (ent_rem[hit_idx] == ChildrenWidth'(1))
          ent_count[hit_idx] <= 1'b1;
      end
      if (do_alloc) begin
        ent_valid[free_idx] <= 1'b1;
        ent_rem[free_idx]   <= packetIn[ChildrenWidth+63:64];
        ent_wait[free_idx]  <= '0;
        // A leaf has nothing to wait for and is eligible immediately.
        ent_count[free_idx] <= (packetIn[ChildrenWidth+63:64] == '0);
      end
    end
  end

  // Entry payload storage: written on allocation and on every combine.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; ent_valid gates every read, so clearing it would only cost reset fan-out.
    if (do_hit)
      ent_data[hit_idx][PayloadLen-1:0] <=
        combine(ent_data[hit_idx][23:22], ent_data[hit_idx][PayloadLen-1:0],
                packetIn[PayloadLen-1:0]);
    if (do_alloc)
      ent_data[free_idx] <= packetIn[61:0];
  end

  // Output register: loads when empty or when the current word is being taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      packetOut <= '0;
      outValid  <= 1'b0;
    end else if (load_ok) begin
      outValid <= rel || bypass_load;
      if (rel)
        packetOut <= {2'b11, ent_data[elig_idx]};
      else if (bypass_load)
        packetOut <= packetIn[63:0];
    end
  end

endmodule
